// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state encodings, parameter defaults and request record
// for the dmem_responder slice.
package dmem_pkg;

  localparam int DEPTH_WORDS_DEFAULT = 256;
  localparam int WAIT_CYCLES_DEFAULT = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dmem_req_t;

  // A request is rejected when it is not word aligned or lands past the last stored word.
  function automatic logic addr_is_bad(input logic [31:0] addr, input int depth);
    logic [31:0] word_idx;
    logic [31:0] limit;
    word_idx = {2'b00, addr[31:2]};
    limit    = depth;
    return (addr[1:0] != 2'b00) || (word_idx >= limit);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port word storage with byte-enabled synchronous write
// and a registered read captured on the commit edge.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
  parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) begin
      rdata_d = mem_q[addr];
    end
  end

  // Storage is deliberately left out of reset so contents survive a clear.
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (en && we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data memory responder with fixed
// wait-state latency, alignment/range error checking and byte-enabled stores.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  dmem_req_t   req_q, req_d;
  logic        err_q, err_d;
  logic        load_q, load_d;

  dmem_req_t   incoming;
  dmem_req_t   cmd;
  logic        cmd_bad;
  logic        commit;
  logic        arr_en;
  logic [31:0] arr_rdata;

  assign incoming = '{write: req_write, addr: req_addr, wdata: req_wdata, be: req_be};

  // With zero wait states the commit happens on the accepting edge, so the
  // array must see the live request rather than the captured copy.
  assign cmd     = (state_q == ST_IDLE) ? incoming : req_q;
  assign cmd_bad = addr_is_bad(cmd.addr, DEPTH_WORDS);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    err_d   = err_q;
    load_d  = load_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d = incoming;
          if (WAIT_CYCLES == 0) begin
            commit  = 1'b1;
            state_d = ST_RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (commit) begin
      err_d  = cmd_bad;
      load_d = !cmd.write;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      err_q   <= err_d;
      load_q  <= load_d;
    end
  end

  // A clear on the commit edge wins, so the access never reaches storage.
  assign arr_en = commit && !cmd_bad && !clr;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (cmd.write),
    .be    (cmd.be),
    .addr  (cmd.addr[AW+1:2]),
    .wdata (cmd.wdata),
    .rdata (arr_rdata)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && load_q && !err_q) ? arr_rdata : 32'h0;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning number of 32-bit words stored.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning added wait states per access (range 0..15).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port clr  input  1  meaning synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  meaning the initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  meaning the responder can accept a request.
REQ-007 SHALL have port req_write  input  1  meaning 1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  meaning byte address.
REQ-009 SHALL have port req_wdata  input  32  meaning store data.
REQ-010 SHALL have port req_be  input  4  meaning store byte enables; bit i enables wdata[8i+7:8i].
REQ-011 SHALL have port rsp_valid  output  1  meaning a response is presented.
REQ-012 SHALL have port rsp_ready  input  1  meaning the initiator accepts the response.
REQ-013 SHALL have port rsp_rdata  output  32  meaning load data.
REQ-014 SHALL have port rsp_err  output  1  meaning the request was misaligned or out of range.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-016 SHALL accept a request on an edge where req_valid && req_ready, capturing write, addr, wdata and be.
REQ-017 SHALL, on acceptance, go to WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0, else go directly to RESP and commit on that edge.
REQ-018 SHALL, in WAIT, decrement the counter each cycle and on the cycle where it is 0, commit the access and go to RESP.
REQ-019 SHALL give a fixed latency: rsp_valid rises WAIT_CYCLES+1 cycles after the accepting edge.
REQ-020 SHALL allow one outstanding request; no request is accepted in WAIT or RESP.
REQ-021 SHALL flag an error when addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS; an error request SHALL NOT read or modify storage.
REQ-022 SHALL, on store commit, write only bytes whose be bit is set; be=4'b0000 SHALL complete without error and modify nothing.
REQ-023 SHALL, on load commit, place word addr[31:2] on rsp_rdata; req_be is ignored for loads.
REQ-024 SHALL drive rsp_rdata=0 for stores and error responses, and rsp_err=1 only for errors.
REQ-025 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then return to IDLE on that edge.
REQ-026 SHALL NOT accept a new request on the edge that leaves RESP; the earliest next accept is one cycle later in IDLE.
REQ-027 SHALL make a store visible to any load accepted after that store's response handshake.

Reset
REQ-028 SHALL, when clr=1 at an edge, enter IDLE, clear the counter and drive rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready=1 after reset.
REQ-029 SHALL, on clr during WAIT before the commit edge, discard the request with no storage write.
REQ-030 SHALL leave storage contents unchanged by clr; the bench SHALL preload them.
REQ-031 SHALL give clr priority over every simultaneous event, including a request handshake.

Structure
REQ-032 SHALL place the state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2) and the defaults for DEPTH_WORDS and WAIT_CYCLES in shared package dmem_pkg.
REQ-033 SHALL isolate storage in sub-module dmem_array: single port, synchronous byte-enabled write, read on the commit edge.
REQ-034 SHALL keep the FSM, counter and error check in dmem_responder; target size is 120-400 RTL lines.

Verification
REQ-035 Store 0xDEADBEEF, be=1111, addr 0x10, then load 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, latency 3 cycles at WAIT_CYCLES=2.
REQ-036 Word 0x20 preloaded with 0x11223344, store 0xAABBCCDD with be=0101 -> a load returns 0x11BB33DD.
REQ-037 Load addr 0x13 (misaligned) and addr 0x400 at DEPTH_WORDS=256 -> rsp_err=1, rsp_rdata=0, storage unchanged.
REQ-038 Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stay stable, req_ready=0, a second request is not accepted.
REQ-039 Assert clr one cycle after accepting a store of 0x55 to 0x8 -> IDLE next cycle, rsp_valid=0, word 0x8 still holds its preload.
REQ-040 Run at WAIT_CYCLES=0 -> rsp_valid one cycle after accept; back-to-back requests with rsp_ready=1 are accepted every 2 cycles.
